norm_l1_engine: RTL

//  Parametrised L1 row normaliser for the SFP stage: accepts rows of COL signed psums, buffers them

---
 rtl/norm_l1_engine.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/norm_l1_engine.sv
// L1 row normaliser: buffers signed rows with their abs-sum in a FIFO, then divides each element
// by (sum >> SUM_SHIFT) using COL parallel restoring dividers, one quotient bit per cycle.
module norm_l1_engine #(
  parameter int unsigned COL       = 8,
  parameter int unsigned BW_PSUM   = 20,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned FRAC      = 0,
  parameter int unsigned SUM_SHIFT = 0,
  localparam int unsigned SW       = BW_PSUM + $clog2(COL),
  localparam int unsigned CW       = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BW_PSUM*COL-1:0]   in_data,
  output logic [SW-1:0]            sum_out,
  output logic [CW-1:0]            count,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BW_PSUM*COL-1:0]   out_data,
  output logic                     out_dz
);

  localparam int unsigned QW = BW_PSUM + FRAC;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned IW = $clog2(QW);

  typedef enum logic [1:0] {StIdle, StDiv, StHold} state_e;

  function automatic logic [BW_PSUM-1:0] abs_val(input logic [BW_PSUM-1:0] x);
    return x[BW_PSUM-1] ? (~x + BW_PSUM'(1)) : x;
  endfunction

  function automatic logic [BW_PSUM-1:0] sat_signed(input logic [QW-1:0] mag, input logic neg);
    logic [QW-1:0] lim;
    lim = QW'(1) << (BW_PSUM - 1);
    if (neg) return (mag >= lim) ? {1'b1, {(BW_PSUM-1){1'b0}}}
                                 : (~mag[BW_PSUM-1:0] + BW_PSUM'(1));
    return (mag >= lim) ? {1'b0, {(BW_PSUM-1){1'b1}}} : mag[BW_PSUM-1:0];
  endfunction

  // Row/sum FIFO
  logic [BW_PSUM*COL-1:0] row_mem [DEPTH];
  logic [SW-1:0]          sum_mem [DEPTH];
  logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]          count_q;
  logic [SW-1:0]          sum_out_q;
  logic [SW-1:0]          row_sum;
  logic                   push, pop;
  logic [BW_PSUM*COL-1:0] head_row;
  logic [SW-1:0]          head_sum, divisor_in;

  // Engine state
  state_e                 state_q;
  logic [QW-1:0]          mag_q [COL];
  logic [SW-1:0]          rem_q [COL];
  logic [COL-1:0]         neg_q;
  logic [SW-1:0]          div_q;
  logic [IW-1:0]          iter_q;
  logic                   out_valid_q, out_dz_q;
  logic [BW_PSUM*COL-1:0] out_data_q;

  logic [SW:0]            rem_sh  [COL];
  logic [SW-1:0]          rem_nxt [COL];
  logic [QW-1:0]          mag_nxt [COL];
  logic [BW_PSUM-1:0]     res     [COL];
  logic [COL-1:0]         q_bit;

  always_comb begin
    row_sum = '0;
    for (int i = 0; i < COL; i++) begin
      row_sum = row_sum + SW'(abs_val(in_data[BW_PSUM*i +: BW_PSUM]));
    end
  end

  // in_ready is held low during reset, otherwise tracks registered occupancy only
  assign in_ready   = reset & (count_q != CW'(DEPTH));
  assign push       = in_valid & in_ready & ~flush;
  assign pop        = (state_q == StIdle) & (count_q != '0) & ~flush;
  assign head_row   = row_mem[rd_ptr_q];
  assign head_sum   = sum_mem[rd_ptr_q];
  assign divisor_in = head_sum >> SUM_SHIFT;

  always_ff @(posedge clk) begin
    if (push) begin
      row_mem[wr_ptr_q] <= in_data;
      sum_mem[wr_ptr_q] <= row_sum;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      sum_out_q <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q  <= wr_ptr_q + AW'(1);
        sum_out_q <= row_sum;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // One restoring step per element: bring next dividend bit into the remainder, subtract if fits
  always_comb begin
    for (int i = 0; i < COL; i++) begin
      rem_sh[i]  = {rem_q[i], mag_q[i][QW-1]};
      q_bit[i]   = rem_sh[i] >= {1'b0, div_q};
      rem_nxt[i] = q_bit[i] ? SW'(rem_sh[i] - {1'b0, div_q}) : rem_sh[i][SW-1:0];
      mag_nxt[i] = {mag_q[i][QW-2:0], q_bit[i]};
      res[i]     = sat_signed(mag_nxt[i], neg_q[i]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      out_dz_q    <= 1'b0;
      out_data_q  <= '0;
      div_q       <= '0;
      iter_q      <= '0;
      neg_q       <= '0;
      for (int i = 0; i < COL; i++) begin
        mag_q[i] <= '0;
        rem_q[i] <= '0;
      end
    end else if (flush) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (pop) begin
            div_q  <= divisor_in;
            iter_q <= IW'(QW - 1);
            for (int i = 0; i < COL; i++) begin
              mag_q[i] <= QW'(abs_val(head_row[BW_PSUM*i +: BW_PSUM])) << FRAC;
              rem_q[i] <= '0;
              neg_q[i] <= head_row[BW_PSUM*i+BW_PSUM-1];
            end
            if (divisor_in == '0) begin
              state_q     <= StHold;
              out_valid_q <= 1'b1;
              out_dz_q    <= 1'b1;
              out_data_q  <= '0;
            end else begin
              state_q <= StDiv;
            end
          end
        end
        StDiv: begin
          for (int i = 0; i < COL; i++) begin
            mag_q[i] <= mag_nxt[i];
            rem_q[i] <= rem_nxt[i];
          end
          iter_q <= iter_q - IW'(1);
          if (iter_q == '0) begin
            state_q     <= StHold;
            out_valid_q <= 1'b1;
            out_dz_q    <= 1'b0;
            for (int i = 0; i < COL; i++) begin
              out_data_q[BW_PSUM*i +: BW_PSUM] <= res[i];
            end
          end
        end
        StHold: begin
          if (out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign sum_out   = sum_out_q;
  assign count     = count_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_dz    = out_dz_q;

endmodule
